// File: rtl/riscv_aes_pkg.sv
// Shared types and widths for the AES memory fetch / write-back engines.
package riscv_aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_WORD_W  = 32;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StErr
  } aes_state_e;

endpackage

// File: rtl/riscv_aes_timeout_cnt.sv
// Per-word watchdog: counts cycles while enabled, saturates at MaxWait and
// flags expiry on the cycle that uses up the last allowed cycle.
module riscv_aes_timeout_cnt #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_WAIT);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear wins over enable; saturate so a late response can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !clr_i && (cnt_q >= CntLast);

endmodule

// File: rtl/riscv_aes_rd.sv
// AES block fetch engine: reads NUM_WORDS consecutive words from data memory
// into one block while holding the core halted.
module riscv_aes_rd
  import riscv_aes_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = 4,
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned MAX_WAIT    = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_aes_rd,
  input  logic [31:0]                       address_in,
  output logic                              mem_req_o,
  output logic [31:0]                       mem_addr_o,
  input  logic                              mem_gnt_i,
  input  logic                              mem_rvalid_i,
  input  logic [31:0]                       mem_rdata_i,
  output logic                              halt_en_out,
  output logic [NUM_WORDS*AES_WORD_W-1:0]   data_out,
  output logic                              done_out,
  output logic                              err_out
);

  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

  aes_state_e      state_q;
  logic [31:0]     base_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     next_addr;
  logic            timer_clr, timer_en, timer_expired;

  // Address of the word after the current one; wraps modulo 2^32.
  assign next_addr = base_q + (32'(idx_q) + 32'd1) * ADDR_STRIDE;

  // Watchdog restarts on every entry to REQ and runs across REQ and WAIT.
  always_comb begin
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    unique case (state_q)
      StIdle: timer_clr = start_aes_rd;
      StReq:  timer_en  = 1'b1;
      StWait: begin
        if (mem_rvalid_i && (idx_q != LastIdx)) begin
          timer_clr = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  riscv_aes_timeout_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expire_o (timer_expired)
  );

  // Fetch FSM with registered outputs; done/err are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      idx_q       <= '0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      halt_en_out <= 1'b0;
      data_out    <= '0;
      done_out    <= 1'b0;
      err_out     <= 1'b0;
    end else begin
      done_out <= 1'b0;
      err_out  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_aes_rd) begin
            base_q      <= address_in;
            idx_q       <= '0;
            data_out    <= '0;
            halt_en_out <= 1'b1;
            mem_req_o   <= 1'b1;
            mem_addr_o  <= address_in;
            state_q     <= StReq;
          end
        end
        StReq: begin
          // A grant on the last allowed cycle still counts as in time.
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_q   <= StWait;
          end else if (timer_expired) begin
            mem_req_o <= 1'b0;
            state_q   <= StErr;
          end
        end
        StWait: begin
          if (mem_rvalid_i) begin
            for (int unsigned k = 0; k < NUM_WORDS; k++) begin
              if (idx_q == IdxW'(k)) begin
                data_out[k*AES_WORD_W +: AES_WORD_W] <= mem_rdata_i;
              end
            end
            if (idx_q == LastIdx) begin
              state_q <= StDone;
            end else begin
              idx_q      <= idx_q + IdxW'(1);
              mem_req_o  <= 1'b1;
              mem_addr_o <= next_addr;
              state_q    <= StReq;
            end
          end else if (timer_expired) begin
            state_q <= StErr;
          end
        end
        StDone: begin
          done_out    <= 1'b1;
          halt_en_out <= 1'b0;
          state_q     <= StIdle;
        end
        StErr: begin
          done_out    <= 1'b1;
          err_out     <= 1'b1;
          halt_en_out <= 1'b0;
          mem_req_o   <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
